// File: rtl/bike_pkg.sv
// Shared constants and types for the bicycle-computer divider arbiter.
package bike_pkg;

  localparam int unsigned W_DEFAULT = 20;
  localparam int unsigned NREQ      = 3;

  localparam int unsigned REQ_SPD = 0;
  localparam int unsigned REQ_AVS = 1;
  localparam int unsigned REQ_DSP = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/div_core.sv
// Iterative restoring divider: load latches operands, each step retires one quotient bit.
module div_core #(
  parameter int unsigned W = bike_pkg::W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_nxt,
  output logic [W-1:0] rem_nxt
);

  logic [W-1:0] quo_q, rem_q, dvs_q;
  logic [W:0]   shifted;
  logic         ge;

  // Step result is exposed combinationally so the caller can capture the final bit directly.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    ge      = shifted >= {1'b0, dvs_q};
    if (ge) begin
      rem_nxt = W'(shifted - {1'b0, dvs_q});
      quo_nxt = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[W-1:0];
      quo_nxt = {quo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/bike_div_arbiter.sv
// Fixed-priority arbiter and sequencer sharing one div_core between speed, avs and display.
module bike_div_arbiter
  import bike_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    dividend0,
  input  logic [W-1:0]    dividend1,
  input  logic [W-1:0]    dividend2,
  input  logic [W-1:0]    divisor0,
  input  logic [W-1:0]    divisor1,
  input  logic [W-1:0]    divisor2,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    quotient,
  output logic [W-1:0]    remainder,
  output logic            div0,
  output logic            busy
);

  localparam int unsigned CW = $clog2(W);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, pick;
  logic [W-1:0]    sel_a, sel_b;
  logic [W-1:0]    op_a_q;
  logic            zero_q;
  logic [W-1:0]    quo_q, rem_q;
  logic            div0_q;
  logic            load, step, last;
  logic [W-1:0]    core_quo, core_rem;

  always_comb begin
    pick  = '0;
    sel_a = '0;
    sel_b = '0;
    if (req[REQ_SPD]) begin
      pick[REQ_SPD] = 1'b1;
      sel_a         = dividend0;
      sel_b         = divisor0;
    end else if (req[REQ_AVS]) begin
      pick[REQ_AVS] = 1'b1;
      sel_a         = dividend1;
      sel_b         = divisor1;
    end else if (req[REQ_DSP]) begin
      pick[REQ_DSP] = 1'b1;
      sel_a         = dividend2;
      sel_b         = divisor2;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d   = pick;
          load    = 1'b1;
          cnt_d   = CW'(W - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_DONE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign last = (state_q == ST_BUSY) && (cnt_q == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      op_a_q  <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      if (load) begin
        op_a_q <= sel_a;
        zero_q <= (sel_b == '0);
      end
      // Results are captured on entry to DONE, including the final iteration's bit.
      if (last) begin
        quo_q  <= zero_q ? '1 : core_quo;
        rem_q  <= zero_q ? op_a_q : core_rem;
        div0_q <= zero_q;
      end
    end
  end

  div_core #(
    .W(W)
  ) u_div_core (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .dividend (sel_a),
    .divisor  (sel_b),
    .quo_nxt  (core_quo),
    .rem_nxt  (core_rem)
  );

  assign gnt       = gnt_q;
  assign done      = (state_q == ST_DONE) ? gnt_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_bike_div_arbiter.sv
// Bench for bike_div_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_bike_div_arbiter;

  localparam int W = 20;

  logic         clock = 1'b0;
  logic         reset;
  logic [2:0]   req;
  logic [W-1:0] dvd [3];
  logic [W-1:0] dvs [3];
  logic [2:0]   gnt, done;
  logic [W-1:0] quotient, remainder;
  logic         div0, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  bike_div_arbiter #(
    .W(W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .dividend0 (dvd[0]),
    .dividend1 (dvd[1]),
    .dividend2 (dvd[2]),
    .divisor0  (dvs[0]),
    .divisor1  (dvs[1]),
    .divisor2  (dvs[2]),
    .gnt       (gnt),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: owner index, cycles since grant, and last captured result.
  int           m_owner = -1;
  int           m_age   = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic         m_div0 = 1'b0;

  function automatic int lowest(input logic [2:0] r);
    if (r[0]) return 0;
    if (r[1]) return 1;
    return 2;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_owner <= -1;
      m_age   <= 0;
      m_q     <= '0;
      m_r     <= '0;
      m_div0  <= 1'b0;
    end else if (m_owner < 0) begin
      if (req != 3'b000) begin
        m_owner <= lowest(req);
        m_age   <= 0;
        m_a     <= dvd[lowest(req)];
        m_b     <= dvs[lowest(req)];
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == W) begin
        if (m_b == '0) begin
          m_q <= '1;
          m_r <= m_a;
        end else begin
          m_q <= m_a / m_b;
          m_r <= m_a % m_b;
        end
        m_div0 <= (m_b == '0);
      end
      if (m_age + 1 == W + 1) m_owner <= -1;
    end
  end

  function automatic logic [2:0] exp_gnt();
    return (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
  endfunction

  function automatic logic [2:0] exp_done();
    return (m_owner >= 0 && m_age == W) ? exp_gnt() : 3'b000;
  endfunction

  always @(negedge clock) begin
    if (checking) begin
      chk("model_gnt", 32'(gnt), 32'(exp_gnt()));
      chk("model_done", 32'(done), 32'(exp_done()));
      chk("model_busy", 32'(busy), 32'(m_owner >= 0));
      chk("model_quotient", 32'(quotient), 32'(m_q));
      chk("model_remainder", 32'(remainder), 32'(m_r));
      chk("model_div0", 32'(div0), 32'(m_div0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dvd[i] = a;
    dvs[i] = b;
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    for (int i = 0; i < 3; i++) set_op(i, '0, '0);
    cyc(3);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_quotient", 32'(quotient), 0);
    reset    = 1'b0;
    checking = 1'b1;
    cyc(1);

    // Single request, speed/avs path
    set_op(1, 1000, 7);
    req = 3'b010;
    cyc(1);
    chk("t1_gnt", 32'(gnt), 32'h2);
    cyc(20);
    chk("t1_done", 32'(done), 32'h2);
    chk("t1_quotient", 32'(quotient), 142);
    chk("t1_remainder", 32'(remainder), 6);
    req = 3'b000;
    cyc(2);

    // Simultaneous requests: index 0 first, then 2
    set_op(0, 255000, 3600);
    set_op(2, 9999, 10);
    req = 3'b101;
    cyc(1);
    chk("t2_gnt0", 32'(gnt), 32'h1);
    cyc(20);
    chk("t2_done0", 32'(done), 32'h1);
    chk("t2_quotient0", 32'(quotient), 70);
    chk("t2_remainder0", 32'(remainder), 3000);
    req = 3'b100;
    cyc(22);
    chk("t2_done2", 32'(done), 32'h4);
    chk("t2_quotient2", 32'(quotient), 999);
    chk("t2_remainder2", 32'(remainder), 9);
    req = 3'b000;
    cyc(2);

    // Divide by zero
    set_op(2, 1234, 0);
    req = 3'b100;
    cyc(21);
    chk("t3_done", 32'(done), 32'h4);
    chk("t3_quotient", 32'(quotient), 32'hFFFFF);
    chk("t3_remainder", 32'(remainder), 1234);
    chk("t3_div0", 32'(div0), 1);
    req = 3'b000;
    cyc(2);

    // Reset mid-division
    set_op(1, 1000, 7);
    req = 3'b010;
    cyc(10);
    reset = 1'b1;
    req   = 3'b000;
    cyc(1);
    chk("t4_gnt", 32'(gnt), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_quotient", 32'(quotient), 0);
    chk("t4_remainder", 32'(remainder), 0);
    chk("t4_div0", 32'(div0), 0);
    reset = 1'b0;
    cyc(1);
    req = 3'b010;
    cyc(21);
    chk("t4_done_fresh", 32'(done), 32'h2);
    chk("t4_quotient_fresh", 32'(quotient), 142);
    req = 3'b000;
    cyc(2);

    // Operand extremes
    set_op(0, 20'hFFFFF, 1);
    req = 3'b001;
    cyc(21);
    chk("t5a_done", 32'(done), 32'h1);
    chk("t5a_quotient", 32'(quotient), 32'hFFFFF);
    chk("t5a_remainder", 32'(remainder), 0);
    req = 3'b000;
    cyc(2);
    set_op(0, 5, 20'hFFFFF);
    req = 3'b001;
    cyc(21);
    chk("t5b_done", 32'(done), 32'h1);
    chk("t5b_quotient", 32'(quotient), 0);
    chk("t5b_remainder", 32'(remainder), 5);
    req = 3'b000;
    cyc(2);

    // Held request is re-served; a higher-priority request raised mid-BUSY waits
    set_op(1, 1000, 7);
    req = 3'b010;
    cyc(21);
    chk("t6_done1a", 32'(done), 32'h2);
    cyc(5);
    set_op(0, 100, 9);
    req = 3'b011;
    cyc(1);
    chk("t6_gnt_no_preempt", 32'(gnt), 32'h2);
    cyc(16);
    chk("t6_done1b", 32'(done), 32'h2);
    chk("t6_quotient1b", 32'(quotient), 142);
    req = 3'b001;
    cyc(22);
    chk("t6_done0", 32'(done), 32'h1);
    chk("t6_quotient0", 32'(quotient), 11);
    chk("t6_remainder0", 32'(remainder), 1);
    req = 3'b000;
    cyc(3);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
